// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter.
// Source tags identify which producer a broadcast came from.
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH_BIT = 4;
    localparam int CDB_SRC_BIT   = 2;

    typedef enum logic [CDB_SRC_BIT-1:0] {
        CDB_SRC_RS = 2'd0,
        CDB_SRC_LB = 2'd1,
        CDB_SRC_SB = 2'd2
    } cdb_src_e;

    // Advance a round-robin index over the three producers, wrapping 2 -> 0.
    function automatic logic [CDB_SRC_BIT-1:0] rr_offset(input logic [CDB_SRC_BIT-1:0] base,
                                                          input logic [CDB_SRC_BIT-1:0] off);
        logic [CDB_SRC_BIT:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[CDB_SRC_BIT-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small synchronous FIFO holding results from one producer until the CDB grants it.
// Flush drops all entries; the payload storage itself is never reset.
module cdb_arbiter_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single registered CDB broadcast between
// the RS/ALU, load buffer and store buffer, each buffered by a private FIFO.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_ID_W   = ROB_WIDTH_BIT
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clear_all,
    input  logic                   rs_valid,
    output logic                   rs_ready,
    input  logic [31:0]            rs_value,
    input  logic [ROB_ID_W-1:0]    rs_dest,
    input  logic [31:0]            rs_jalr_pc,
    input  logic                   lb_valid,
    output logic                   lb_ready,
    input  logic [31:0]            lb_value,
    input  logic [ROB_ID_W-1:0]    lb_dest,
    input  logic                   sb_valid,
    output logic                   sb_ready,
    input  logic [ROB_ID_W-1:0]    sb_dest,
    output logic                   cdb_valid,
    output logic [CDB_SRC_BIT-1:0] cdb_src,
    output logic [ROB_ID_W-1:0]    cdb_dest,
    output logic [31:0]            cdb_value,
    output logic [31:0]            cdb_jalr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RS_W  = 64 + ROB_ID_W;
    localparam int LB_W  = 32 + ROB_ID_W;
    localparam int SB_W  = ROB_ID_W;

    logic             accept_ok;
    logic             flush;
    logic             advance;
    logic [CNT_W-1:0] rs_count, lb_count, sb_count;
    logic             rs_empty, lb_empty, sb_empty;
    logic [RS_W-1:0]  rs_head;
    logic [LB_W-1:0]  lb_head;
    logic [SB_W-1:0]  sb_head;
    logic             rs_pop, lb_pop, sb_pop;
    logic [2:0]       req;

    logic [CDB_SRC_BIT-1:0] rr_ptr;
    logic [CDB_SRC_BIT-1:0] cand;
    logic [CDB_SRC_BIT-1:0] grant_idx;
    logic                   grant_any;
    logic [ROB_ID_W-1:0]    nxt_dest;
    logic [31:0]            nxt_value;
    logic [31:0]            nxt_jalr;

    // Readiness looks only at registered counts, so a full FIFO never accepts even while draining.
    assign accept_ok = rst_in & rdy_in & ~clear_all;
    assign rs_ready  = accept_ok & (rs_count < CNT_W'(FIFO_DEPTH));
    assign lb_ready  = accept_ok & (lb_count < CNT_W'(FIFO_DEPTH));
    assign sb_ready  = accept_ok & (sb_count < CNT_W'(FIFO_DEPTH));

    assign flush   = rdy_in & clear_all;
    assign advance = rdy_in & ~clear_all & grant_any;
    assign req     = {~sb_empty, ~lb_empty, ~rs_empty};

    assign rs_pop = advance & (grant_idx == CDB_SRC_RS);
    assign lb_pop = advance & (grant_idx == CDB_SRC_LB);
    assign sb_pop = advance & (grant_idx == CDB_SRC_SB);

    cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RS_W)) u_rs_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush),
        .push      (rs_valid & rs_ready),
        .push_data ({rs_value, rs_dest, rs_jalr_pc}),
        .pop       (rs_pop),
        .head      (rs_head),
        .empty     (rs_empty),
        .count     (rs_count)
    );

    cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(LB_W)) u_lb_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush),
        .push      (lb_valid & lb_ready),
        .push_data ({lb_value, lb_dest}),
        .pop       (lb_pop),
        .head      (lb_head),
        .empty     (lb_empty),
        .count     (lb_count)
    );

    cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SB_W)) u_sb_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush),
        .push      (sb_valid & sb_ready),
        .push_data (sb_dest),
        .pop       (sb_pop),
        .head      (sb_head),
        .empty     (sb_empty),
        .count     (sb_count)
    );

    // Scan offsets from farthest to nearest so the candidate closest to rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 2; off >= 0; off--) begin
            cand = rr_offset(rr_ptr, CDB_SRC_BIT'(off));
            if (req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        nxt_dest  = '0;
        nxt_value = '0;
        nxt_jalr  = '0;
        case (grant_idx)
            CDB_SRC_RS: {nxt_value, nxt_dest, nxt_jalr} = rs_head;
            CDB_SRC_LB: {nxt_value, nxt_dest}           = lb_head;
            CDB_SRC_SB: nxt_dest                        = sb_head;
            default:    nxt_dest                        = '0;
        endcase
    end

    // Flush wins over arbitration; a pause freezes every register including cdb_valid.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_src     <= '0;
            cdb_dest    <= '0;
            cdb_value   <= '0;
            cdb_jalr_pc <= '0;
        end else if (rdy_in) begin
            if (clear_all) begin
                cdb_valid <= 1'b0;
            end else if (grant_any) begin
                cdb_valid   <= 1'b1;
                cdb_src     <= grant_idx;
                cdb_dest    <= nxt_dest;
                cdb_value   <= nxt_value;
                cdb_jalr_pc <= nxt_jalr;
                rr_ptr      <= rr_offset(grant_idx, 2'd1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based producer model predicts each
// broadcast, and a negedge monitor compares the DUT against those predictions.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DW    = ROB_WIDTH_BIT;
    localparam int DEPTH = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b0;
    logic          clear_all = 1'b0;
    logic          rs_valid = 1'b0, lb_valid = 1'b0, sb_valid = 1'b0;
    logic          rs_ready, lb_ready, sb_ready;
    logic [31:0]   rs_value = '0, rs_jalr_pc = '0, lb_value = '0;
    logic [DW-1:0] rs_dest = '0, lb_dest = '0, sb_dest = '0;
    logic          cdb_valid;
    logic [1:0]    cdb_src;
    logic [DW-1:0] cdb_dest;
    logic [31:0]   cdb_value, cdb_jalr_pc;

    typedef struct packed {
        logic          valid;
        logic [1:0]    src;
        logic [DW-1:0] dest;
        logic [31:0]   value;
        logic [31:0]   jalr;
    } bcast_t;

    bcast_t exp_q[$];
    bcast_t q_rs[$], q_lb[$], q_sb[$];
    bcast_t last = '0;
    int     rr = 0;
    int     checks = 0;
    int     passes = 0;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(DW)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_all   (clear_all),
        .rs_valid    (rs_valid),
        .rs_ready    (rs_ready),
        .rs_value    (rs_value),
        .rs_dest     (rs_dest),
        .rs_jalr_pc  (rs_jalr_pc),
        .lb_valid    (lb_valid),
        .lb_ready    (lb_ready),
        .lb_value    (lb_value),
        .lb_dest     (lb_dest),
        .sb_valid    (sb_valid),
        .sb_ready    (sb_ready),
        .sb_dest     (sb_dest),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_dest    (cdb_dest),
        .cdb_value   (cdb_value),
        .cdb_jalr_pc (cdb_jalr_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q_rs.size();
            1:       return q_lb.size();
            default: return q_sb.size();
        endcase
    endfunction

    // Monitor: each expected entry belongs to one clock edge and is compared half a cycle later.
    always @(negedge clk_in) begin
        bcast_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
                checkOutput("cdb_bcast", {cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc}, e);
            end else begin
                checkOutput("cdb_idle", cdb_valid, 0);
            end
        end
    end

    // Drive one cycle of inputs, check readiness, and predict the result of the coming edge.
    task automatic applyStimulus(input logic r, input logic c,
                                 input logic rv, input logic lv, input logic sv,
                                 input logic [DW-1:0] rd, input logic [DW-1:0] ld, input logic [DW-1:0] sd,
                                 input logic [31:0] rval, input logic [31:0] rjalr, input logic [31:0] lval);
        bit     acc_rs, acc_lb, acc_sb, found;
        int     idx;
        bcast_t item;
        @(negedge clk_in);
        #1;
        rdy_in = r; clear_all = c;
        rs_valid = rv; lb_valid = lv; sb_valid = sv;
        rs_dest = rd; lb_dest = ld; sb_dest = sd;
        rs_value = rval; rs_jalr_pc = rjalr; lb_value = lval;
        #1;
        acc_rs = r && !c && (q_rs.size() < DEPTH);
        acc_lb = r && !c && (q_lb.size() < DEPTH);
        acc_sb = r && !c && (q_sb.size() < DEPTH);
        checkOutput("rs_ready", rs_ready, acc_rs);
        checkOutput("lb_ready", lb_ready, acc_lb);
        checkOutput("sb_ready", sb_ready, acc_sb);
        if (r && c) begin
            q_rs.delete(); q_lb.delete(); q_sb.delete();
            last.valid = 1'b0;
        end else if (r) begin
            found = 0;
            idx = 0;
            for (int k = 0; k < 3; k++) begin
                if (!found && qsize((rr + k) % 3) > 0) begin
                    found = 1;
                    idx = (rr + k) % 3;
                end
            end
            if (found) begin
                case (idx)
                    0:       last = q_rs.pop_front();
                    1:       last = q_lb.pop_front();
                    default: last = q_sb.pop_front();
                endcase
                rr = (idx + 1) % 3;
            end else begin
                last.valid = 1'b0;
            end
            if (acc_rs && rv) begin
                item = '{valid: 1'b1, src: 2'd0, dest: rd, value: rval, jalr: rjalr};
                q_rs.push_back(item);
            end
            if (acc_lb && lv) begin
                item = '{valid: 1'b1, src: 2'd1, dest: ld, value: lval, jalr: 32'h0};
                q_lb.push_back(item);
            end
            if (acc_sb && sv) begin
                item = '{valid: 1'b1, src: 2'd2, dest: sd, value: 32'h0, jalr: 32'h0};
                q_sb.push_back(item);
            end
        end
        exp_q.push_back(last);
    endtask

    task automatic idle_cycle();
        applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        int lbd;
        bit acc;

        // Held in reset with active inputs: nothing may be accepted or broadcast.
        rdy_in = 1; rs_valid = 1; lb_valid = 1; sb_valid = 1;
        repeat (2) @(negedge clk_in);
        #1;
        checkOutput("reset_readys", {rs_ready, lb_ready, sb_ready}, 3'b000);
        checkOutput("reset_cdb", {cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc}, '0);
        rs_valid = 0; lb_valid = 0; sb_valid = 0;
        rst_in = 1;

        repeat (2) idle_cycle();

        // Single RS result with latency check.
        applyStimulus(1, 0, 1, 0, 0, 4'd5, '0, '0, 32'h0000_00AB, 32'h0000_1000, '0);
        repeat (3) idle_cycle();

        // Bring rr_ptr back to RS with a lone store completion.
        applyStimulus(1, 0, 0, 0, 1, '0, '0, 4'd15, '0, '0, '0);
        repeat (2) idle_cycle();

        // Round robin: expect dests 1,3,6,2,4,7.
        applyStimulus(1, 0, 1, 1, 1, 4'd1, 4'd3, 4'd6, 32'h11, 32'h2000, 32'h33);
        applyStimulus(1, 0, 1, 1, 1, 4'd2, 4'd4, 4'd7, 32'h22, 32'h2004, 32'h44);
        repeat (7) idle_cycle();

        // Backpressure on the load buffer while RS and SB keep the bus busy.
        lbd = 10;
        for (int n = 0; n < 30 && lbd < 14; n++) begin
            acc = (q_lb.size() < DEPTH);
            applyStimulus(1, 0, 1, 1, 1, DW'(n % 8), DW'(lbd), DW'(n % 8),
                          32'(n), 32'(n * 4), 32'(lbd + 100));
            if (acc) lbd++;
        end
        checkOutput("lb_all_accepted", lbd, 14);

        // Flush with queued entries and an RS result being offered.
        repeat (3) applyStimulus(1, 0, 1, 1, 1, 4'd1, 4'd2, 4'd3, 32'h5, 32'h6, 32'h7);
        applyStimulus(1, 1, 1, 0, 0, 4'd8, '0, '0, 32'h8, 32'h9, '0);
        repeat (3) idle_cycle();

        // Pause with dest 9 on the bus and LB 8 queued behind it.
        applyStimulus(1, 0, 1, 0, 0, 4'd9, '0, '0, 32'h99, 32'h900, '0);
        applyStimulus(1, 0, 0, 1, 0, '0, 4'd8, '0, '0, '0, 32'h88);
        repeat (3) applyStimulus(0, 1, 1, 1, 1, 4'd1, 4'd2, 4'd3, 32'h1, 32'h2, 32'h3);
        repeat (2) idle_cycle();

        // Randomized traffic, pauses and occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          DW'($urandom), DW'($urandom), DW'($urandom),
                          $urandom, $urandom, $urandom);
        end

        // Asynchronous reset with results still queued.
        repeat (4) applyStimulus(1, 0, 1, 1, 1, 4'd3, 4'd4, 4'd5, 32'hA, 32'hB, 32'hC);
        @(negedge clk_in);
        #2;
        rst_in = 0;
        #1;
        checkOutput("async_reset_cdb", {cdb_valid, cdb_src, cdb_dest, cdb_value, cdb_jalr_pc}, '0);
        checkOutput("async_reset_readys", {rs_ready, lb_ready, sb_ready}, 3'b000);
        q_rs.delete(); q_lb.delete(); q_sb.delete();
        last = '0;
        rr = 0;
        rs_valid = 0; lb_valid = 0; sb_valid = 0;
        repeat (2) @(negedge clk_in);
        #1;
        rst_in = 1;
        repeat (3) idle_cycle();

        @(negedge clk_in);
        #2;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single result broadcast path into the ROB (and its RS/LSB snoopers) between three producers: RS/ALU, load buffer, store buffer.
- Each producer hands off results over a valid/ready handshake into a private FIFO. The arbiter issues at most one registered broadcast per cycle, using round-robin priority.
- Sits between the execution units and the ROB listen ports. A flush (clear_all) discards every queued result.

Parameters:
- FIFO_DEPTH, 2, entries per producer FIFO (power of two, ≥2).
- ROB_ID_W, `ROB_WIDTH_BIT, width of ROB destination tag.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global pause when low.
- clear_all  in  1  flush from ROB.
- rs_valid  in  1  RS result present.
- rs_ready  out  1  RS result accepted this cycle when rs_valid & rs_ready.
- rs_value  in  32  ALU result.
- rs_dest  in  ROB_ID_W  ROB tag.
- rs_jalr_pc  in  32  jalr target.
- lb_valid  in  1  load result present.
- lb_ready  out  1  load accept.
- lb_value  in  32  load data.
- lb_dest  in  ROB_ID_W  ROB tag.
- sb_valid  in  1  store completion present.
- sb_ready  out  1  store accept.
- sb_dest  in  ROB_ID_W  ROB tag.
- cdb_valid  out  1  broadcast valid.
- cdb_src  out  2  0=RS, 1=LB, 2=SB.
- cdb_dest  out  ROB_ID_W  broadcast tag.
- cdb_value  out  32  broadcast data (0 for SB).
- cdb_jalr_pc  out  32  jalr target (0 unless src=RS).

Behaviour:
- Reset (rst_in low, async): all FIFO counts/pointers 0, rr_ptr=0, cdb_valid=0, cdb_src=0, cdb_dest=0, cdb_value=0, cdb_jalr_pc=0. The ready outputs read 0 while in reset.
- Readiness:
  - x_ready = rdy_in & !clear_all & (count_x < FIFO_DEPTH), computed combinationally from registered count only.
  - A full FIFO does not accept a push, even if it pops the same cycle.
- Accept: on an edge with x_valid & x_ready, the payload is written at the FIFO tail. Simultaneous push and pop on the same FIFO is legal and leaves the count unchanged.
- Arbitration (combinational, each cycle rdy_in=1):
  - Candidate set = non-empty FIFOs.
  - Grant goes to the first candidate at or after rr_ptr in order 0,1,2 wrapping.
  - On grant to i: pop FIFO i, load its head into the cdb_* registers, cdb_valid<=1, rr_ptr<=(i+1) mod 3.
  - With no candidate: cdb_valid<=0, other cdb_* hold, rr_ptr holds.
- Latency:
  - Payload accepted at edge k reaches cdb_* at the earliest at edge k+1 and is visible during cycle k+1..k+2.
  - There is no same-cycle bypass.
  - Throughput is one broadcast per cycle aggregate.
- Ordering: per-producer FIFO order is preserved. There is no ordering guarantee across producers.
- Fairness: with all three FIFOs continuously non-empty, grants cycle strictly 0,1,2,0,…
- Flush (clear_all=1 at an edge with rdy_in=1):
  - All counts and pointers go to 0 and cdb_valid<=0. Any pop/grant that cycle is cancelled.
  - No pushes occur (ready is low). rr_ptr is unchanged.
  - Flush has priority over arbitration.
- Pause (rdy_in=0): all registers hold, including cdb_valid and rr_ptr. Ready is low and clear_all is ignored.
- Wrap-around: FIFO pointers are modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Reset mid-operation: queued results are lost and outputs go to reset values immediately (async).

Decomposition:
- Shared constants in const.v: ROB_WIDTH_BIT (existing), new `CDB_SRC_RS=0, `CDB_SRC_LB=1, `CDB_SRC_SB=2, `CDB_SRC_BIT=2.
- One sub-module, cdb_fifo: parameterised depth/width synchronous FIFO with async active-low reset, push/pop/full/empty/count and flush input. It is instantiated three times with payload widths 32+ROB_ID_W+32 (RS), 32+ROB_ID_W (LB) and ROB_ID_W (SB).
- The top level holds the round-robin pointer, grant logic and output registers.

Test Plan:
- Reset: drive rst_in low mid-cycle with queued entries -> cdb_valid=0 immediately, all readys 0. After release with no valids -> cdb_valid stays 0.
- Single RS result: rs_value=0x0000_00AB, rs_dest=5, rs_jalr_pc=0x1000 accepted at edge 1 -> cdb_valid=1, src=0, dest=5, value=0xAB, jalr_pc=0x1000 after edge 2; cdb_valid=0 after edge 3.
- Round robin: preload RS {d=1,2}, LB {d=3,4}, SB {d=6,7} with rr_ptr=0 -> broadcast dest sequence 1,3,6,2,4,7 on consecutive cycles.
- Backpressure: hold lb_valid for 4 cycles while RS/SB keep the arbiter busy so LB loses grants -> lb_ready drops after FIFO_DEPTH=2 accepts and no value is lost. Dest values 10,11,12,13 appear on cdb in order.
- Flush: three FIFOs holding 5 entries total, assert clear_all for one cycle with rs_valid=1 -> rs_ready=0 that cycle, cdb_valid=0 next cycle, no further broadcasts, counts all 0.
- Pause: cdb_valid=1 with dest=9, rdy_in=0 for 3 cycles -> cdb outputs frozen at dest=9, readys 0, no pops. Resume -> next queued entry broadcast on the following edge.
